// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing controller: function codes, default widths, FSM encoding.
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OPW_DEF   = 6;

  localparam logic [OPW_DEF-1:0] OP_ADD = 6'd32;
  localparam logic [OPW_DEF-1:0] OP_SUB = 6'd34;
  localparam logic [OPW_DEF-1:0] OP_AND = 6'd36;
  localparam logic [OPW_DEF-1:0] OP_OR  = 6'd37;
  localparam logic [OPW_DEF-1:0] OP_SLT = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; combinational, one-hot grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    unique case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = 1'b0;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = 1'b1;
      end
      2'b11: begin
        // On a tie the requester that was not served last wins.
        gnt_id = ~last_gnt;
        gnt    = last_gnt ? 2'b01 : 2'b10;
      end
      default: begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: accept, one EXEC cycle, then hold the
// response until the grantee takes it. One op per 3 cycles at best; no accepts while busy.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid0,
  output logic             req_ready0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [OPW-1:0]   req_op0,
  input  logic             req_valid1,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [OPW-1:0]   req_op1,
  output logic             resp_valid0,
  input  logic             resp_ready0,
  output logic [WIDTH-1:0] resp_data0,
  output logic             resp_err0,
  output logic             resp_valid1,
  input  logic             resp_ready1,
  output logic [WIDTH-1:0] resp_data1,
  output logic             resp_err1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_signal,
  input  logic [WIDTH-1:0] alu_result
);

  state_e           state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic             gnt_id_q, gnt_id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic [1:0] arb_req;
  logic [1:0] arb_gnt;
  logic       arb_gnt_id;
  logic       in_idle;
  logic       in_exec;
  logic       in_resp;
  logic       op_legal;
  logic       resp_take;

  assign arb_req = {req_valid1, req_valid0};

  rr_arb2 u_arb (
    .req      (arb_req),
    .last_gnt (last_gnt_q),
    .gnt      (arb_gnt),
    .gnt_id   (arb_gnt_id)
  );

  // Ready is gated by reset so that every output reads 0 while reset is held.
  assign in_idle = (state_q == ST_IDLE) && !reset;
  assign in_exec = (state_q == ST_EXEC);
  assign in_resp = (state_q == ST_RESP);

  assign req_ready0 = in_idle & arb_gnt[0];
  assign req_ready1 = in_idle & arb_gnt[1];

  assign alu_a      = in_exec ? a_q  : '0;
  assign alu_b      = in_exec ? b_q  : '0;
  assign alu_signal = in_exec ? op_q : '0;

  assign resp_valid0 = in_resp & ~gnt_id_q;
  assign resp_valid1 = in_resp &  gnt_id_q;
  assign resp_data0  = resp_valid0 ? data_q : '0;
  assign resp_data1  = resp_valid1 ? data_q : '0;
  assign resp_err0   = resp_valid0 & err_q;
  assign resp_err1   = resp_valid1 & err_q;

  assign resp_take = gnt_id_q ? resp_ready1 : resp_ready0;

  always_comb begin
    op_legal = (op_q == OPW'(OP_ADD)) || (op_q == OPW'(OP_SUB)) ||
               (op_q == OPW'(OP_AND)) || (op_q == OPW'(OP_OR))  ||
               (op_q == OPW'(OP_SLT));
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_id_d   = gnt_id_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    data_d     = data_q;
    err_d      = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|arb_req) begin
          gnt_id_d = arb_gnt_id;
          a_d      = arb_gnt_id ? req_a1  : req_a0;
          b_d      = arb_gnt_id ? req_b1  : req_b0;
          op_d     = arb_gnt_id ? req_op1 : req_op0;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Illegal codes report zero data regardless of what the ALU returns.
        err_d   = ~op_legal;
        data_d  = op_legal ? alu_result : '0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_take) begin
          last_gnt_d = gnt_id_q;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
      gnt_id_q   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_id_q   <= gnt_id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

endmodule
